// File: rtl/reg_write_arbiter.sv
// Three-requester write arbiter feeding one register-file write port, with a registered write stage.
// Define REG_WRITE_ARB_ROUND_ROBIN_EN for rotating priority; otherwise requester 0 > 1 > 2.
module reg_write_arbiter #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [2:0]      req,
  input  logic [4:0]      rd0,
  input  logic [4:0]      rd1,
  input  logic [4:0]      rd2,
  input  logic [XLEN-1:0] data0,
  input  logic [XLEN-1:0] data1,
  input  logic [XLEN-1:0] data2,
  input  logic            flush,
  output logic [2:0]      gnt,
  output logic            wr_en,
  output logic [4:0]      wr_addr,
  output logic [XLEN-1:0] wr_data,
  output logic [1:0]      gnt_id
);

  logic [1:0]      start;
  logic [1:0]      win;
  logic            xfer;
  logic [2:0]      sum;
  logic [1:0]      cand;
  logic [4:0]      sel_rd;
  logic [XLEN-1:0] sel_data;

`ifdef REG_WRITE_ARB_ROUND_ROBIN_EN
  logic [1:0] ptr;

  assign start = ptr;

  // Pointer moves just past the winner; never reaches 3.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr <= 2'd0;
    end else if (xfer) begin
      ptr <= (win == 2'd2) ? 2'd0 : win + 2'd1;
    end
  end
`else
  assign start = 2'd0;
`endif

  // Grant depends only on req, flush, rst and the search start.
  always_comb begin
    gnt  = '0;
    win  = '0;
    xfer = 1'b0;
    sum  = '0;
    cand = '0;
    if (!rst && !flush) begin
      for (int k = 0; k < 3; k++) begin
        sum = {1'b0, start} + 3'(k);
        if (sum >= 3'd3) sum = sum - 3'd3;
        cand = sum[1:0];
        if (!xfer && req[cand]) begin
          xfer      = 1'b1;
          win       = cand;
          gnt[cand] = 1'b1;
        end
      end
    end
  end

  always_comb begin
    sel_rd   = rd0;
    sel_data = data0;
    case (win)
      2'd1: begin
        sel_rd   = rd1;
        sel_data = data1;
      end
      2'd2: begin
        sel_rd   = rd2;
        sel_data = data2;
      end
      default: ;
    endcase
  end

  // Writes to x0 are accepted from the requester but never reach the register file.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_en   <= 1'b0;
      wr_addr <= '0;
      wr_data <= '0;
      gnt_id  <= '0;
    end else if (xfer) begin
      wr_en   <= (sel_rd != 5'd0);
      wr_addr <= sel_rd;
      wr_data <= sel_data;
      gnt_id  <= win;
    end else begin
      wr_en   <= 1'b0;
    end
  end

endmodule

// File: tb/tb_reg_write_arbiter.sv
// Directed bench for reg_write_arbiter with a reference model and an output scoreboard.
// Follows REG_WRITE_ARB_ROUND_ROBIN_EN to select round-robin or fixed-priority expectations.
module tb_reg_write_arbiter;
  localparam int XLEN = 32;

  logic            clk = 1'b0;
  logic            rst;
  logic [2:0]      req;
  logic [4:0]      rd0, rd1, rd2;
  logic [XLEN-1:0] data0, data1, data2;
  logic            flush;
  logic [2:0]      gnt;
  logic            wr_en;
  logic [4:0]      wr_addr;
  logic [XLEN-1:0] wr_data;
  logic [1:0]      gnt_id;

  reg_write_arbiter #(.XLEN(XLEN)) dut (
    .clk(clk), .rst(rst), .req(req),
    .rd0(rd0), .rd1(rd1), .rd2(rd2),
    .data0(data0), .data1(data1), .data2(data2),
    .flush(flush), .gnt(gnt), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data), .gnt_id(gnt_id)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic            en;
    logic [4:0]      addr;
    logic [XLEN-1:0] data;
    logic [1:0]      id;
  } wr_t;

  wr_t  exp_q[$];
  wr_t  m_out;
  int   m_ptr;
  int   n_assert = 0;
  int   n_fail   = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [2:0] model_gnt(input logic [2:0] r, input logic f);
    logic [2:0] g;
    int i;
    g = '0;
    if (f) return g;
    for (int k = 0; k < 3; k++) begin
      i = (m_ptr + k) % 3;
      if (r[i]) begin
        g[i] = 1'b1;
        return g;
      end
    end
    return g;
  endfunction

  task automatic model_reset();
    m_ptr = 0;
    m_out = '0;
    exp_q.delete();
    exp_q.push_back(m_out);
  endtask

  // One clock cycle: drive at negedge, check grant and last edge's outputs, queue next expectation.
  task automatic cycle(input logic [2:0] r, input logic f,
                       input logic [4:0] a0, input logic [4:0] a1, input logic [4:0] a2,
                       input logic [XLEN-1:0] d0, input logic [XLEN-1:0] d1,
                       input logic [XLEN-1:0] d2);
    logic [2:0] eg;
    wr_t        e;
    @(negedge clk);
    req = r; flush = f;
    rd0 = a0; rd1 = a1; rd2 = a2;
    data0 = d0; data1 = d1; data2 = d2;
    #1;
    eg = model_gnt(r, f);
    chk("gnt", 64'(gnt), 64'(eg));
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("wr_en", 64'(wr_en), 64'(e.en));
      chk("wr_addr", 64'(wr_addr), 64'(e.addr));
      chk("wr_data", 64'(wr_data), 64'(e.data));
      chk("gnt_id", 64'(gnt_id), 64'(e.id));
    end else begin
      chk("scoreboard_underflow", 64'd1, 64'd0);
    end
    m_out.en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      if (eg[i]) begin
        m_out.addr = (i == 0) ? a0 : (i == 1) ? a1 : a2;
        m_out.data = (i == 0) ? d0 : (i == 1) ? d1 : d2;
        m_out.id   = 2'(i);
        m_out.en   = (m_out.addr != 5'd0);
`ifdef REG_WRITE_ARB_ROUND_ROBIN_EN
        m_ptr = (i + 1) % 3;
`endif
      end
    end
    exp_q.push_back(m_out);
  endtask

  task automatic idle();
    cycle(3'b000, 1'b0, 5'd0, 5'd0, 5'd0, '0, '0, '0);
  endtask

  initial begin
    rst = 1'b1; req = 3'b111; flush = 1'b0;
    rd0 = 5'd1; rd1 = 5'd2; rd2 = 5'd3;
    data0 = 32'h11; data1 = 32'h22; data2 = 32'h33;
    #12;
    chk("rst_gnt", 64'(gnt), 64'd0);
    chk("rst_wr_en", 64'(wr_en), 64'd0);
    chk("rst_wr_addr", 64'(wr_addr), 64'd0);
    chk("rst_wr_data", 64'(wr_data), 64'd0);
    chk("rst_gnt_id", 64'(gnt_id), 64'd0);
    @(negedge clk);
    req = 3'b000;
    rst = 1'b0;
    model_reset();

    // Single write from requester 1
    cycle(3'b010, 1'b0, 5'd0, 5'd5, 5'd0, '0, 32'hDEADBEEF, '0);
    idle();

    // Reset arriving between edges clears the registered write immediately
    cycle(3'b001, 1'b0, 5'd9, 5'd0, 5'd0, 32'h99, '0, '0);
    @(posedge clk);
    #2;
    chk("pre_rst_wr_en", 64'(wr_en), 64'd1);
    req = 3'b111;
    rst = 1'b1;
    #1;
    chk("async_rst_wr_en", 64'(wr_en), 64'd0);
    chk("async_rst_gnt", 64'(gnt), 64'd0);
    chk("async_rst_wr_addr", 64'(wr_addr), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    req = 3'b000;
    model_reset();

    // All three requesting for three cycles
    repeat (3) cycle(3'b111, 1'b0, 5'd1, 5'd2, 5'd3, 32'hA0, 32'hA1, 32'hA2);
    idle();

    // Write to x0 is granted but dropped
    cycle(3'b001, 1'b0, 5'd0, 5'd0, 5'd0, 32'h1, '0, '0);
    idle();

    // Flush holds off requester 2, then it proceeds
    cycle(3'b100, 1'b1, 5'd0, 5'd0, 5'd17, '0, '0, 32'hCAFE0002);
    cycle(3'b100, 1'b1, 5'd0, 5'd0, 5'd17, '0, '0, 32'hCAFE0002);
    cycle(3'b100, 1'b0, 5'd0, 5'd0, 5'd17, '0, '0, 32'hCAFE0002);
    idle();

    // A registered write still completes during a flush cycle
    cycle(3'b001, 1'b0, 5'd7, 5'd0, 5'd0, 32'h77, '0, '0);
    cycle(3'b010, 1'b1, 5'd0, 5'd8, 5'd0, '0, 32'h88, '0);
    cycle(3'b010, 1'b0, 5'd0, 5'd8, 5'd0, '0, 32'h88, '0);
    idle();

    // Mixed traffic
    for (int n = 0; n < 40; n++) begin
      cycle(3'($urandom_range(0, 7)), ($urandom_range(0, 5) == 0),
            5'($urandom), 5'($urandom), 5'($urandom),
            $urandom, $urandom, $urandom);
    end
    idle();
    idle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    n_fail++;
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $fatal(1, "timeout");
  end

endmodule
